pc_gen_bpred: RTL and testbench
===============================

// Module: pc_gen_bpred
// PURPOSE
//  Fetch-stage PC generator with a direct-mapped branch target buffer (BTB)
//  and 2-bit saturating direction counters. Owns the PC register and predicts
//  the next fetch PC. Takes resolved branch/jump outcomes from EX, trains the
//  BTB and redirects fetch on a mispredict. Successor to the combinational
//  next-PC mux; sits between the IF PC register and the I-memory address.
// PARAMETERS
//  ADDR_W       32            PC/target width in bits (>= IDX_W+3)
//  BTB_ENTRIES  16            BTB depth; power of 2, >= 2; IDX_W = log2(BTB_ENTRIES)
//  RESET_PC     32'h0000_0000 PC value loaded on reset; bits [1:0] must be 0
//  CTR_INIT     2'b01         counter value written to every entry on reset
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       synchronous, active-high reset
//  stall           in   1       hold the PC (IF/ID stall)
//  pc              out  ADDR_W  current fetch PC (registered)
//  pred_taken      out  1       fetch prediction for pc; travels down the pipe with the instruction
//  pred_target     out  ADDR_W  predicted next PC (BTB target, or pc+4)
//  ex_valid        in   1       EX holds a valid instruction this cycle
//  ex_pc           in   ADDR_W  PC of the EX instruction
//  ex_is_branch    in   1       conditional branch (beq/bne)
//  ex_is_jump      in   1       unconditional jump
//  ex_taken        in   1       resolved direction (forced 1 when ex_is_jump)
//  ex_target       in   ADDR_W  resolved target; bits [1:0] ignored and treated as 0
//  ex_pred_taken   in   1       pred_taken carried with the EX instruction
//  ex_pred_target  in   ADDR_W  pred_target carried with the EX instruction
//  redirect        out  1       combinational mispredict flag; flush IF/ID
//  redirect_pc     out  ADDR_W  correct next PC when redirect=1
//  branch_cnt      out  32      resolved branches and jumps (wraps)
//  mispred_cnt     out  32      redirects issued (wraps)
// BEHAVIOUR
//  Reset: pc=RESET_PC; all BTB valid=0, ctr=CTR_INIT; both counters 0.
//   EX inputs are ignored while rst=1.
//  Lookup (combinational on pc): idx=pc[IDX_W+1:2]; tag=pc[ADDR_W-1:IDX_W+2].
//   hit = valid[idx] & tag match.
//   pred_taken = hit & (jmp[idx] | ctr[idx][1]).
//   pred_target = pred_taken ? tgt[idx] : pc+4.
//  Resolution (ex_valid=1):
//   act_next = (is_branch|is_jump) & ex_taken ? ex_target : ex_pc+4
//   prd_next = ex_pred_taken ? ex_pred_target : ex_pc+4
//   redirect = (act_next != prd_next); redirect_pc = act_next.
//   A non-branch instruction with ex_pred_taken=1 (alias) mispredicts to
//   ex_pc+4 and clears valid at its index if the tag matches.
//  PC update, priority highest first: rst > redirect (load redirect_pc) >
//   stall (hold) > pred_target. Redirect overrides stall.
//  BTB training, at the clock edge, only for ex_valid & (is_branch|is_jump):
//   - Tag hit: tgt<=ex_target; jmp<=is_jump; ctr increments (saturates at 3)
//     if taken, else decrements (saturates at 0).
//   - Miss & taken: allocate valid=1, tag, tgt, jmp; ctr=2'b11 for a jump,
//     2'b10 for a branch.
//   - Miss & not taken: no write.
//  Same-cycle lookup and write to the same index: lookup sees the old contents.
//  Counters: branch_cnt += 1 per resolved branch/jump; mispred_cnt += 1 per
//   redirect; both wrap modulo 2^32.
//  Arithmetic: pc+4 and ex_pc+4 wrap modulo 2^ADDR_W; pc[1:0] is always 0.
//  Latency: one cycle from redirect to the corrected pc; training is visible
//   to a lookup one cycle after the write.
// TESTING
//  1 rst 2 cycles, then run with no EX activity -> pc=0,4,8,...; pred_taken=0.
//  2 Cold beq at 0x20, taken to 0x100 -> redirect=1, redirect_pc=0x100;
//    next pc=0x100; entry allocated with ctr=2; mispred_cnt=1.
//  3 Loop: taken branch at 0x20 seen 3 times, then fetch 0x20 ->
//    pred_taken=1, pred_target=0x100; not-taken resolve -> redirect to 0x24,
//    ctr 3->2.
//  4 stall=1 while redirect=1 -> pc loads redirect_pc; stall alone holds pc
//    for 3 cycles.
//  5 Aliasing: 0x20 and 0x20+4*BTB_ENTRIES share an index -> tag miss,
//    pred_taken=0; a non-branch with ex_pred_taken=1 -> redirect to ex_pc+4,
//    entry invalidated.
//  6 Jump at ADDR_W-max PC 0xFFFF_FFFC, not taken path -> pc+4 wraps to 0;
//    rst asserted mid-redirect -> pc=RESET_PC and no BTB write.

Source files
------------

// File: rtl/pc_gen_bpred.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit direction counters.
// Predicts the next fetch PC, trains on resolved EX outcomes and redirects on mispredicts.
module pc_gen_bpred #(
    parameter int                ADDR_W      = 32,
    parameter int                BTB_ENTRIES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [1:0]        CTR_INIT    = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_is_branch,
    input  logic              ex_is_jump,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       branch_cnt,
    output logic [31:0]       mispred_cnt
);

    localparam int                IDX_W      = $clog2(BTB_ENTRIES);
    localparam int                TAG_W      = ADDR_W - IDX_W - 2;
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic              btb_valid [BTB_ENTRIES];
    logic              btb_jmp   [BTB_ENTRIES];
    logic [1:0]        btb_ctr   [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag   [BTB_ENTRIES];
    logic [ADDR_W-1:0] btb_tgt   [BTB_ENTRIES];

    logic [IDX_W-1:0]  fetch_idx;
    logic [TAG_W-1:0]  fetch_tag;
    logic              fetch_hit;
    logic [ADDR_W-1:0] pc_plus4;

    logic [IDX_W-1:0]  ex_idx;
    logic [TAG_W-1:0]  ex_tag;
    logic              ex_hit;
    logic              ex_ctrl;
    logic              ex_dir;
    logic              ex_live;
    logic              train;
    logic              alias_clear;
    logic [ADDR_W-1:0] ex_tgt_al;
    logic [ADDR_W-1:0] ex_plus4;
    logic [ADDR_W-1:0] act_next;
    logic [ADDR_W-1:0] prd_next;

    assign fetch_idx   = pc[IDX_W+1:2];
    assign fetch_tag   = pc[ADDR_W-1:IDX_W+2];
    assign fetch_hit   = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
    assign pc_plus4    = pc + PC_STEP;
    assign pred_taken  = fetch_hit & (btb_jmp[fetch_idx] | btb_ctr[fetch_idx][1]);
    assign pred_target = pred_taken ? btb_tgt[fetch_idx] : pc_plus4;

    // Jumps are always taken regardless of what EX reports for direction.
    assign ex_ctrl   = ex_is_branch | ex_is_jump;
    assign ex_dir    = ex_is_jump | ex_taken;
    assign ex_tgt_al = ex_target & ALIGN_MASK;
    assign ex_plus4  = ex_pc + PC_STEP;
    assign act_next  = (ex_ctrl && ex_dir) ? ex_tgt_al : ex_plus4;
    assign prd_next  = ex_pred_taken ? ex_pred_target : ex_plus4;
    assign ex_live   = ex_valid & ~rst;

    assign redirect    = ex_live && (act_next != prd_next);
    assign redirect_pc = act_next;

    assign ex_idx      = ex_pc[IDX_W+1:2];
    assign ex_tag      = ex_pc[ADDR_W-1:IDX_W+2];
    assign ex_hit      = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
    assign train       = ex_live & ex_ctrl;
    assign alias_clear = ex_live & ~ex_ctrl & ex_pred_taken & ex_hit;

    // A non-branch that was predicted taken evicts the entry it aliased onto.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_jmp[i]   <= 1'b0;
                btb_ctr[i]   <= CTR_INIT;
                btb_tag[i]   <= '0;
                btb_tgt[i]   <= '0;
            end
        end else if (train && ex_hit) begin
            btb_tgt[ex_idx] <= ex_tgt_al;
            btb_jmp[ex_idx] <= ex_is_jump;
            if (ex_dir) begin
                if (btb_ctr[ex_idx] != 2'b11) begin
                    btb_ctr[ex_idx] <= btb_ctr[ex_idx] + 2'b01;
                end
            end else if (btb_ctr[ex_idx] != 2'b00) begin
                btb_ctr[ex_idx] <= btb_ctr[ex_idx] - 2'b01;
            end
        end else if (train && ex_dir) begin
            btb_valid[ex_idx] <= 1'b1;
            btb_tag[ex_idx]   <= ex_tag;
            btb_tgt[ex_idx]   <= ex_tgt_al;
            btb_jmp[ex_idx]   <= ex_is_jump;
            btb_ctr[ex_idx]   <= ex_is_jump ? 2'b11 : 2'b10;
        end else if (alias_clear) begin
            btb_valid[ex_idx] <= 1'b0;
        end
    end

    // A redirect must win over stall, otherwise the flushed path would be refetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (!stall) begin
            pc <= pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (train) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (redirect) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_bpred.sv
// Scoreboard bench for pc_gen_bpred: expectations are queued as stimulus is
// driven and popped against the DUT outputs on the following falling edge.
module tb_pc_gen_bpred;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic [ADDR_W-1:0] pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_is_branch;
    logic              ex_is_jump;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [31:0]       branch_cnt;
    logic [31:0]       mispred_cnt;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   assertCount = 0;
    int   failCount   = 0;
    int   expBr       = 0;
    int   expMis      = 0;

    pc_gen_bpred dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pc            (pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_is_branch  (ex_is_branch),
        .ex_is_jump    (ex_is_jump),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .ex_pred_target(ex_pred_target),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input string name);
        case (name)
            "pc":          return pc;
            "pred_taken":  return {31'd0, pred_taken};
            "pred_target": return pred_target;
            "redirect":    return {31'd0, redirect};
            "redirect_pc": return redirect_pc;
            "branch_cnt":  return branch_cnt;
            "mispred_cnt": return mispred_cnt;
            default:       return 'x;
        endcase
    endfunction

    task automatic pushExp(input string name, input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.value = value;
        sb.push_back(e);
    endtask

    // Pops every queued expectation on the falling edge, then advances past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.name, observe(e.name), e.value);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] epc, input logic br,
                                 input logic jmp, input logic tk, input logic [31:0] tgt,
                                 input logic ptk, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_pc          = epc;
        ex_is_branch   = br;
        ex_is_jump     = jmp;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic resolveEx(input logic [31:0] epc, input logic br, input logic jmp,
                             input logic tk, input logic [31:0] tgt, input logic ptk,
                             input logic [31:0] ptgt, input logic expRed, input logic [31:0] expRpc);
        pushExp("branch_cnt", expBr);
        pushExp("mispred_cnt", expMis);
        applyStimulus(1'b1, epc, br, jmp, tk, tgt, ptk, ptgt);
        pushExp("redirect", {31'd0, expRed});
        if (expRed) pushExp("redirect_pc", expRpc);
        cycle();
        if (br || jmp) expBr++;
        if (expRed) expMis++;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    // A non-branch predicted taken steers fetch to addr without training the BTB.
    task automatic redirectTo(input logic [31:0] addr);
        resolveEx(addr - 32'd4, 1'b0, 1'b0, 1'b0, '0, 1'b1, addr ^ 32'h1000_0000, 1'b1, addr);
    endtask

    task automatic fetchCheck(input logic [31:0] addr, input logic ptk, input logic [31:0] ptgt);
        pushExp("pc", addr);
        pushExp("pred_taken", {31'd0, ptk});
        pushExp("pred_target", ptgt);
        cycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Sequential fetch from reset with no EX activity
        pushExp("branch_cnt", 32'd0);
        pushExp("mispred_cnt", 32'd0);
        for (int i = 0; i < 6; i++) begin
            fetchCheck(32'(4 * i), 1'b0, 32'(4 * i + 4));
        end

        // Cold taken branch allocates with ctr=2
        resolveEx(32'h20, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h24, 1'b1, 32'h100);
        fetchCheck(32'h100, 1'b0, 32'h104);

        // Loop training, then two not-taken resolves walk ctr 3->2->1
        resolveEx(32'h20, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, '0);
        resolveEx(32'h20, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, '0);
        redirectTo(32'h20);
        fetchCheck(32'h20, 1'b1, 32'h100);
        resolveEx(32'h20, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h24);
        fetchCheck(32'h24, 1'b0, 32'h28);
        redirectTo(32'h20);
        fetchCheck(32'h20, 1'b1, 32'h100);
        resolveEx(32'h20, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h24);
        redirectTo(32'h20);
        fetchCheck(32'h20, 1'b0, 32'h24);

        // Redirect overrides stall, then stall alone holds pc
        stall = 1'b1;
        redirectTo(32'h40);
        for (int i = 0; i < 3; i++) fetchCheck(32'h40, 1'b0, 32'h44);
        stall = 1'b0;
        fetchCheck(32'h40, 1'b0, 32'h44);
        fetchCheck(32'h44, 1'b0, 32'h48);

        // Aliasing on index 8: tag miss, mismatched-tag alias keeps entry, matching alias clears it
        resolveEx(32'h20, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, '0);
        redirectTo(32'h60);
        fetchCheck(32'h60, 1'b0, 32'h64);
        resolveEx(32'h60, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b1, 32'h64);
        redirectTo(32'h20);
        fetchCheck(32'h20, 1'b1, 32'h100);
        resolveEx(32'h20, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b1, 32'h24);
        fetchCheck(32'h24, 1'b0, 32'h28);
        redirectTo(32'h20);
        fetchCheck(32'h20, 1'b0, 32'h24);

        // Top of address space: pc+4 and ex_pc+4 wrap; jump forces taken and ignores target[1:0]
        redirectTo(32'hFFFF_FFFC);
        fetchCheck(32'hFFFF_FFFC, 1'b0, 32'h0);
        fetchCheck(32'h0, 1'b0, 32'h4);
        resolveEx(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b1, 32'h0);
        resolveEx(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h203, 1'b0, 32'h0, 1'b1, 32'h200);
        fetchCheck(32'h200, 1'b0, 32'h204);
        redirectTo(32'hFFFF_FFFC);
        fetchCheck(32'hFFFF_FFFC, 1'b1, 32'h200);

        // Reset during a mispredicting jump: no training, everything back to reset values
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h84);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        expBr  = 0;
        expMis = 0;
        pushExp("branch_cnt", 32'd0);
        pushExp("mispred_cnt", 32'd0);
        fetchCheck(32'h0, 1'b0, 32'h4);
        redirectTo(32'h80);
        fetchCheck(32'h80, 1'b0, 32'h84);

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
